// File: rtl/uart_program_loader.sv
// uart_program_loader: assembles big-endian 32-bit words from a UART byte
// stream and writes them into instruction memory from word 0.
// Frame: LEN_HI, LEN_LO (word count N), then 4*N data bytes, MSB first.
// Optional feature macro: LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module uart_program_loader #(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load_start,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
`ifdef LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE
    } state_t;

    // Largest legal word count: exactly fills memory.
    localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_WIDTH;

    state_t                state_q, state_d;
    logic [15:0]           len_q, len_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;      // one extra bit so N = depth compares cleanly
    logic [1:0]            idx_q, idx_d;
    logic [23:0]           word_q, word_d;    // first three bytes of the word in flight
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]            csum_q, csum_d;
`endif

    logic [15:0]           len_full;
    logic [ADDR_WIDTH:0]   cnt_inc;
    logic                  last_word;
    state_t                end_state;

    assign len_full  = {len_q[15:8], rx_data};
    assign cnt_inc   = cnt_q + 1'b1;
    assign last_word = ({1'b0, len_q} == 17'(cnt_inc));
`ifdef LOADER_CHECKSUM_EN
    assign end_state = S_CHK;
`else
    assign end_state = S_DONE;
`endif

    // Next-state and datapath update for the frame parser.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        word_d  = word_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;
        err_d   = err_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (load_start) begin
                    state_d = S_LEN_HI;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    idx_d   = '0;
`ifdef LOADER_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            S_LEN_HI: begin
                if (rx_valid) begin
                    len_d   = {rx_data, 8'h00};
                    state_d = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (rx_valid) begin
                    len_d = len_full;
                    if (len_full == 16'd0) begin
                        state_d = end_state;
                    end else if ({1'b0, len_full} > MAX_WORDS) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (rx_valid) begin
                    word_d = {word_q[15:0], rx_data};
                    idx_d  = idx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ rx_data;
`endif
                    if (idx_q == 2'd3) begin
                        we_d    = 1'b1;
                        addr_d  = cnt_q[ADDR_WIDTH-1:0];
                        wdata_d = {word_q, rx_data};
                        cnt_d   = cnt_inc;
                        if (last_word) state_d = end_state;
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
                if (rx_valid) begin
                    err_d   = (rx_data != csum_q);
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // busy covers the done pulse so it drops one cycle after done
        busy_d = (state_d != S_IDLE) || done_d;
    end

    // State and output registers; reset returns every output to zero at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            word_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: doc/uart_program_loader.md
# uart_program_loader

Byte-stream program loader for the single-cycle MIPS core: the writer end of the instruction path that the decode stage reads from. It takes bytes from the UART receiver, assembles big-endian 32-bit instruction words and writes them sequentially into instruction memory from word address 0, holding the CPU in `busy` while loading. It sits between the UART receiver and the instruction RAM write port, muxed ahead of normal fetch.

## Interface
- `ADDR_WIDTH`, 14, instruction memory word-address width; depth = 2^ADDR_WIDTH words.
- `clock`  in  1  system clock, all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high; clock `clock`.
- `load_start`  in  1  one-cycle request to begin a load; honoured only in IDLE.
- `rx_valid`  in  1  one-cycle strobe, `rx_data` valid this cycle.
- `rx_data`  in  8  received byte.
- `imem_we`  out  1  instruction RAM write enable, one-cycle pulse per word.
- `imem_addr`  out  ADDR_WIDTH  word address for the write.
- `imem_wdata`  out  32  assembled instruction word.
- `busy`  out  1  high from accepted `load_start` until return to IDLE; drives CPU hold.
- `done`  out  1  one-cycle pulse at end of a completed load.
- `err`  out  1  sticky error; cleared on next accepted `load_start`.

## Operation
- Frame: LEN_HI, LEN_LO (16-bit word count N, big-endian), then 4·N data bytes, each word MSB first (first byte → bits 31:24).
- States: IDLE, LEN_HI, LEN_LO, DATA, CHK (macro only), DONE.
- IDLE: `rx_valid` ignored. `load_start` → LEN_HI, `busy`=1, `err`=0, word address=0, byte index=0.
- LEN_HI: on `rx_valid` latch high byte → LEN_LO.
- LEN_LO: on `rx_valid` latch low byte, evaluate N:
  - N=0 → DONE (or CHK with macro, expected checksum 0x00).
  - N > 2^ADDR_WIDTH → `err`=1, → IDLE, no writes, no `done`.
  - otherwise → DATA.
- DATA: each `rx_valid` shifts byte into the word register; on 4th byte issue write, increment address, clear byte index. After write N → DONE (or CHK).
- DONE: assert `done` one cycle, → IDLE.
- `load_start` while `busy` ignored. Bytes arriving in DONE ignored.
- Address counter is ADDR_WIDTH+1 bits internally for the N compare; N = 2^ADDR_WIDTH is legal and fills memory exactly; no wrap ever occurs.

## Timing
- Reset values: `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `busy`=0, `done`=0, `err`=0, state IDLE.
- `busy` rises the cycle after `load_start` is sampled.
- `imem_we` high exactly the cycle after the edge sampling the 4th byte of a word; `imem_addr`/`imem_wdata` stable that cycle; `imem_addr` = word index k for word k.
- `done` high the cycle after the final write (or checksum byte); `busy` falls the cycle after `done`.
- Error abort: `busy` falls the cycle after LEN_LO sampled; `err` rises same edge.
- Reset mid-load: immediate return to IDLE with reset values; words already written stay in memory.
- `rx_valid` on consecutive cycles must be accepted with no byte loss.

## Configuration
- `LOADER_CHECKSUM_EN` defined: after the last data word (or LEN_LO when N=0) FSM enters CHK and waits one byte; expected value = XOR of all data bytes. Match → DONE, `err`=0; mismatch → DONE with `err`=1 set same edge (`done` still pulses). Written words are not rolled back.
- Not defined: no CHK state, no checksum logic; DONE follows last write directly.

## Test plan
- Reset, `load_start`, bytes 00 02 12 34 56 78 9A BC DE F0 → writes 0x12345678@0, 0x9ABCDEF0@1, one `done`, `err`=0, `busy` low after.
- Back-to-back `rx_valid` every cycle, N=3 → three `imem_we` pulses, addresses 0,1,2, no lost bytes.
- Length 00 00 → no `imem_we`, `done` pulse (with macro: after checksum byte 0x00).
- ADDR_WIDTH=4, length 00 11 → `err`=1, no writes, no `done`, back to IDLE; next `load_start` clears `err`.
- `load_start` pulsed mid-DATA, and `reset` asserted after 6 data bytes → first ignored; reset drops all outputs to 0 immediately, word 0 written, word 1 not written.
- With `LOADER_CHECKSUM_EN`, N=1, data 01 02 03 04, checksum 0x04 → `done`, `err`=0; checksum 0x05 → `done`, `err`=1.
